circuit_2_fsmd: RTL and testbench

//  Scheduled (FSMD) form of the circuit_2 dataflow: same function, but one shared add/sub unit
//  and one comparator, time-multiplexed by a controller with a Start/Done handshake.

---
 rtl/circuit_fsmd_pkg.sv | 20 ++
 rtl/fsmd_addsub.sv | 16 +
 rtl/circuit_2_fsmd.sv | 146 ++++++++++++++
 tb/tb_circuit_2_fsmd.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/circuit_fsmd_pkg.sv
// Shared controller/datapath definitions for the scheduled FSMD circuits.
package circuit_fsmd_pkg;

  localparam int unsigned STATE_W = 3;

  // Controller states; encoding fixed so later FSMD circuits can share it.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    S_D   = 3'd1,
    S_E   = 3'd2,
    S_F   = 3'd3,
    S_OUT = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Shared add/sub unit opcodes.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fsmd_addsub.sv
// Shared combinational adder/subtractor; wraps modulo 2^DATAWIDTH.
module fsmd_addsub
  import circuit_fsmd_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] B,
  input  logic                 op,
  output logic [DATAWIDTH-1:0] Y
);

  // Carry/borrow out is intentionally dropped.
  assign Y = (op == OP_SUB) ? (A - B) : (A + B);

endmodule

// File: rtl/circuit_2_fsmd.sv
// circuit_2 scheduled onto one add/sub unit and one comparator with a Start/Done handshake.
module circuit_2_fsmd
  import circuit_fsmd_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  output logic                 Busy,
  output logic                 Done,
  output logic [DATAWIDTH-1:0] x,
  output logic [DATAWIDTH-1:0] z
);

  state_e state_q, state_d;

  logic [DATAWIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [DATAWIDTH-1:0] d_q, d_d, e_q, e_d, f_q, f_d;
  logic [DATAWIDTH-1:0] x_q, x_d, z_q, z_d;
  logic                 lt_q, lt_d, eq_q, eq_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic [DATAWIDTH-1:0] au_b_c, au_y_c;
  logic                 au_op_c;
  logic [DATAWIDTH-1:0] g_c, h_c;

  // Operand-select mux for the shared unit: A is always a; B/op depend on the step.
  always_comb begin
    au_b_c  = b_q;
    au_op_c = OP_ADD;
    case (state_q)
      S_E:     au_b_c  = c_q;
      S_F:     au_op_c = OP_SUB;
      default: ;
    endcase
  end

  fsmd_addsub #(.DATAWIDTH(DATAWIDTH)) u_addsub (
    .A  (a_q),
    .B  (au_b_c),
    .op (au_op_c),
    .Y  (au_y_c)
  );

  // Output-stage selects, consumed only in S_OUT.
  always_comb begin
    g_c = lt_q ? e_q : d_q;
    h_c = eq_q ? f_q : g_c;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    e_d     = e_q;
    f_d     = f_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    x_d     = x_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = a;
          b_d     = b;
          c_d     = c;
          state_d = S_D;
        end
      end
      S_D: begin
        d_d     = au_y_c;
        state_d = S_E;
      end
      S_E: begin
        e_d     = au_y_c;
        state_d = S_F;
      end
      S_F: begin
        f_d     = au_y_c;
        lt_d    = (d_q < e_q);
        eq_d    = (d_q == e_q);
        state_d = S_OUT;
      end
      S_OUT: begin
        x_d     = g_c << lt_q;
        z_d     = h_c >> eq_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered from the next state so they align with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Controller state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      e_q    <= '0;
      f_q    <= '0;
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
      x_q    <= '0;
      z_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      d_q    <= d_d;
      e_q    <= e_d;
      f_q    <= f_d;
      lt_q   <= lt_d;
      eq_q   <= eq_d;
      x_q    <= x_d;
      z_q    <= z_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign x    = x_q;
  assign z    = z_q;

endmodule

// File: tb/tb_circuit_2_fsmd.sv
// Directed self-checking bench for circuit_2_fsmd.
module tb_circuit_2_fsmd;

  logic        Clk, Rst, Start;
  logic [31:0] a, b, c;
  logic        Busy, Done;
  logic [31:0] x, z;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_x = 32'd0;
  logic [31:0] exp_z = 32'd0;

  typedef struct {
    logic [31:0] a, b, c;
    logic [31:0] x, z;
  } vec_t;

  vec_t vecs[6];

  circuit_2_fsmd #(.DATAWIDTH(32)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .a     (a),
    .b     (b),
    .c     (c),
    .Busy  (Busy),
    .Done  (Done),
    .x     (x),
    .z     (z)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  // One Start pulse; checks latency, hold of old results, new results and handshake fall.
  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input logic [31:0] ci,
                        input logic [31:0] xe, input logic [31:0] ze,
                        input bit zero_after, input string nm);
    int n;
    a = ai; b = bi; c = ci; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    if (zero_after) begin
      a = '0; b = '0; c = '0;
    end
    chk({nm, "_busy"}, 32'(Busy), 32'd1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (Done) begin
        n = i;
        break;
      end
      chk({nm, "_hold_x"}, x, exp_x);
    end
    chk({nm, "_latency"}, 32'(n), 32'd4);
    chk({nm, "_x"}, x, xe);
    chk({nm, "_z"}, z, ze);
    @(negedge Clk);
    chk({nm, "_done_fall"}, 32'(Done), 32'd0);
    chk({nm, "_busy_fall"}, 32'(Busy), 32'd0);
    exp_x = xe;
    exp_z = ze;
  endtask

  initial begin
    int cnt, first, second;

    vecs[0] = '{a: 32'd5,          b: 32'd3, c: 32'd10, x: 32'd30, z: 32'd15};
    vecs[1] = '{a: 32'd4,          b: 32'd6, c: 32'd6,  x: 32'd10, z: 32'h7FFF_FFFF};
    vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'd1, c: 32'd2,  x: 32'd2,  z: 32'd1};
    vecs[3] = '{a: 32'd10,         b: 32'd7, c: 32'd2,  x: 32'd17, z: 32'd17};
    vecs[4] = '{a: 32'd100,        b: 32'd0, c: 32'd1,  x: 32'd202, z: 32'd101};
    vecs[5] = '{a: 32'd0,          b: 32'd0, c: 32'd0,  x: 32'd0,  z: 32'd0};

    Rst = 1'b1; Start = 1'b0; a = '0; b = '0; c = '0;
    #2 Rst = 1'b0;
    #1;
    chk("rst_x", x, 32'd0);
    chk("rst_z", z, 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // Table-driven single operations.
    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].x, vecs[i].z, 1'b0, $sformatf("vec%0d", i));

    // Wrap case again so x differs from the held-Start result below.
    run_op(vecs[2].a, vecs[2].b, vecs[2].c, vecs[2].x, vecs[2].z, 1'b0, "wrap");

    // Start held for 8 edges: accept at k, ignored until IDLE, re-accept at k+6.
    a = 32'd5; b = 32'd3; c = 32'd10; Start = 1'b1;
    cnt = 0; first = -1; second = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (i == 7) Start = 1'b0;
      if (i == 3) chk("held_hold_x", x, 32'd2);
      if (Done) begin
        cnt++;
        if (first < 0) first = i;
        else second = i;
      end
    end
    chk("held_done_count", 32'(cnt), 32'd2);
    chk("held_first_done", 32'(first), 32'd4);
    chk("held_second_done", 32'(second), 32'd10);
    chk("held_x", x, 32'd30);
    chk("held_z", z, 32'd15);
    chk("held_busy_end", 32'(Busy), 32'd0);
    exp_x = 32'd30; exp_z = 32'd15;

    // Inputs cleared right after the accept edge must not affect the result.
    run_op(vecs[2].a, vecs[2].b, vecs[2].c, vecs[2].x, vecs[2].z, 1'b0, "pre_chg");
    run_op(32'd5, 32'd3, 32'd10, 32'd30, 32'd15, 1'b1, "chg_inputs");

    // Reset mid-operation aborts with no Done.
    a = 32'd5; b = 32'd3; c = 32'd10; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("abort_x", x, 32'd0);
    chk("abort_z", z, 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (Done || Busy) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    exp_x = 32'd0; exp_z = 32'd0;
    run_op(32'd4, 32'd6, 32'd6, 32'd10, 32'h7FFF_FFFF, 1'b0, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
